// File: rtl/pkfb_pkg.sv
// Shared definitions for the packet-FIFO push front end.
// Contents: data/timestamp widths, maximum channel count, FSM state type.
// Optional feature macro: PKFB_TSTAMP_HDR_EN adds the HDR state.
package pkfb_pkg;

  localparam int unsigned PKFB_DATA_W = 32;
  localparam int unsigned PKFB_TS_W   = 24;
  localparam int unsigned PKFB_MAX_CH = 4;

`ifdef PKFB_TSTAMP_HDR_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    HDR   = 2'd3
  } pkfb_state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } pkfb_state_e;
`endif

endpackage

// File: rtl/pkfb_rr_arbiter.sv
// Round-robin request encoder: searches req_i from ptr_i upward (mod N)
// and returns the first requesting index.
// Ports:
//   req_i       per-requester request
//   ptr_i       starting index of the search
//   gnt_valid_o at least one request present
//   gnt_idx_o   index of the selected requester
module pkfb_rr_arbiter
  import pkfb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          gnt_valid_o,
  output logic [PW-1:0] gnt_idx_o
);

  // One spare bit so ptr+k never wraps before the modulo-N correction.
  logic [PW:0] cand;

  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = {1'b0, ptr_i} + (PW+1)'(k);
      if (cand >= (PW+1)'(N)) begin
        cand = cand - (PW+1)'(N);
      end
      if (!gnt_valid_o && req_i[cand[PW-1:0]]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = cand[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/pkfb_stream_arbiter.sv
// Multi-channel front end for the fabric packet-FIFO push port.
// Arbitrates NUM_CH valid/ready word streams round-robin at packet
// boundaries, pushes framed words one cycle after acceptance, forces EOF at
// MAX_PKT_WORDS and discards the rest of a packet after FIFO overflow.
// Ports:
//   Sys_PKfb_Clk / Sys_PKfb_Rst_n   clock, async active-low reset
//   Ch_Data/Ch_Valid/Ch_Last/Ch_Ready  per-channel word streams
//   FB_PKfbOverflow                 FIFO dropped a push
//   TimeStamp                       header timestamp (feature only)
//   Ovf_Clr / Ovf_Sticky            per-channel sticky overflow status
//   FB_PKfbData/Push/SOF/EOF        registered push interface
//   Busy                            FSM not idle
// Optional feature macro: PKFB_TSTAMP_HDR_EN (timestamp header per grant).
module pkfb_stream_arbiter
  import pkfb_pkg::*;
#(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned MAX_PKT_WORDS = 256,
  parameter int unsigned CNT_W         = $clog2(MAX_PKT_WORDS)
) (
  input  logic                          Sys_PKfb_Clk,
  input  logic                          Sys_PKfb_Rst_n,
  input  logic [NUM_CH*PKFB_DATA_W-1:0] Ch_Data,
  input  logic [NUM_CH-1:0]             Ch_Valid,
  input  logic [NUM_CH-1:0]             Ch_Last,
  output logic [NUM_CH-1:0]             Ch_Ready,
  input  logic                          FB_PKfbOverflow,
  input  logic [PKFB_TS_W-1:0]          TimeStamp,
  input  logic [NUM_CH-1:0]             Ovf_Clr,
  output logic [PKFB_DATA_W-1:0]        FB_PKfbData,
  output logic [NUM_CH-1:0]             FB_PKfbPush,
  output logic                          FB_PKfbSOF,
  output logic                          FB_PKfbEOF,
  output logic [NUM_CH-1:0]             Ovf_Sticky,
  output logic                          Busy
);

  localparam int unsigned PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  pkfb_state_e            state_q;
  logic [PW-1:0]          grant_q, ptr_q, ptr_nxt;
  logic [CNT_W-1:0]       cnt_q;
  logic [PKFB_DATA_W-1:0] data_q, sel_data;
  logic [NUM_CH-1:0]      push_q, gnt_oh, ovf_sticky_q, ovf_sticky_d;
  logic                   sof_q, eof_q;
  logic                   sel_valid, sel_last, rd_en, accept, word_eof, in_xfer;
  logic                   arb_valid;
  logic [PW-1:0]          arb_idx;

  pkfb_rr_arbiter #(
    .N  (NUM_CH),
    .PW (PW)
  ) u_rr (
    .req_i       (Ch_Valid),
    .ptr_i       (ptr_q),
    .gnt_valid_o (arb_valid),
    .gnt_idx_o   (arb_idx)
  );

  always_comb begin
    gnt_oh    = '0;
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant_q == PW'(i)) begin
        gnt_oh[i] = 1'b1;
        sel_data  = Ch_Data[i*PKFB_DATA_W +: PKFB_DATA_W];
        sel_valid = Ch_Valid[i];
        sel_last  = Ch_Last[i];
      end
    end
  end

  assign rd_en    = (state_q == XFER) || (state_q == DRAIN);
  assign Ch_Ready = rd_en ? gnt_oh : '0;
  assign accept   = rd_en && sel_valid;
  assign word_eof = sel_last || (cnt_q == CNT_W'(MAX_PKT_WORDS - 1));
  assign ptr_nxt  = (grant_q == PW'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;

`ifdef PKFB_TSTAMP_HDR_EN
  logic [1:0]             hdr_ch;
  logic [PKFB_DATA_W-1:0] hdr_word;
  always_comb begin
    hdr_ch             = '0;
    hdr_ch[PW-1:0]     = grant_q;
  end
  assign hdr_word = {4'h0, 2'b00, hdr_ch, TimeStamp};
  assign in_xfer  = (state_q == XFER) || (state_q == HDR);
`else
  logic unused_ts;
  assign unused_ts = ^TimeStamp;
  assign in_xfer   = (state_q == XFER);
`endif

  // Set beats a simultaneous clear on the same bit.
  assign ovf_sticky_d = (ovf_sticky_q & ~Ovf_Clr) |
                        ((in_xfer && FB_PKfbOverflow) ? gnt_oh : '0);

  always_ff @(posedge Sys_PKfb_Clk or negedge Sys_PKfb_Rst_n) begin
    if (!Sys_PKfb_Rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      data_q       <= '0;
      push_q       <= '0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      ovf_sticky_q <= '0;
    end else begin
      data_q       <= '0;
      push_q       <= '0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      ovf_sticky_q <= ovf_sticky_d;
      unique case (state_q)
        IDLE: begin
          if (arb_valid) begin
            grant_q <= arb_idx;
            cnt_q   <= '0;
`ifdef PKFB_TSTAMP_HDR_EN
            state_q <= HDR;
`else
            state_q <= XFER;
`endif
          end
        end
`ifdef PKFB_TSTAMP_HDR_EN
        HDR: begin
          if (FB_PKfbOverflow) begin
            state_q <= DRAIN;
          end else begin
            data_q  <= hdr_word;
            push_q  <= gnt_oh;
            sof_q   <= 1'b1;
            cnt_q   <= CNT_W'(1);
            state_q <= XFER;
          end
        end
`endif
        XFER: begin
          // On overflow the word accepted this cycle is dropped, not pushed.
          if (FB_PKfbOverflow) begin
            if (accept && word_eof) begin
              ptr_q   <= ptr_nxt;
              state_q <= IDLE;
            end else begin
              state_q <= DRAIN;
            end
          end else if (accept) begin
            data_q <= sel_data;
            push_q <= gnt_oh;
            sof_q  <= (cnt_q == '0);
            eof_q  <= word_eof;
            cnt_q  <= cnt_q + 1'b1;
            if (word_eof) begin
              ptr_q   <= ptr_nxt;
              state_q <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (accept && sel_last) begin
            ptr_q   <= ptr_nxt;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign FB_PKfbData = data_q;
  assign FB_PKfbPush = push_q;
  assign FB_PKfbSOF  = sof_q;
  assign FB_PKfbEOF  = eof_q;
  assign Ovf_Sticky  = ovf_sticky_q;
  assign Busy        = (state_q != IDLE);

endmodule

// File: tb/tb_pkfb_stream_arbiter.sv
`timescale 1ns/1ps
module tb_pkfb_stream_arbiter;

  localparam int unsigned NCH  = 4;
  localparam int unsigned MAXW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH*32-1:0] Ch_Data;
  logic [NCH-1:0]    Ch_Valid, Ch_Last, Ch_Ready, Ovf_Clr, Ovf_Sticky, FB_PKfbPush;
  logic              FB_PKfbOverflow, FB_PKfbSOF, FB_PKfbEOF, Busy;
  logic [23:0]       TimeStamp;
  logic [31:0]       FB_PKfbData;

  pkfb_stream_arbiter #(
    .NUM_CH        (NCH),
    .MAX_PKT_WORDS (MAXW)
  ) dut (
    .Sys_PKfb_Clk    (clk),
    .Sys_PKfb_Rst_n  (rst_n),
    .Ch_Data         (Ch_Data),
    .Ch_Valid        (Ch_Valid),
    .Ch_Last         (Ch_Last),
    .Ch_Ready        (Ch_Ready),
    .FB_PKfbOverflow (FB_PKfbOverflow),
    .TimeStamp       (TimeStamp),
    .Ovf_Clr         (Ovf_Clr),
    .FB_PKfbData     (FB_PKfbData),
    .FB_PKfbPush     (FB_PKfbPush),
    .FB_PKfbSOF      (FB_PKfbSOF),
    .FB_PKfbEOF      (FB_PKfbEOF),
    .Ovf_Sticky      (Ovf_Sticky),
    .Busy            (Busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } word_t;

  word_t       src_q [NCH][$];
  logic [37:0] exp_q [$];        // {push, data, sof, eof}
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic send(input int ch, input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) src_q[ch].push_back('{d: base + 32'(k), l: (k == n - 1)});
  endtask

  task automatic exp_word(input int ch, input logic [31:0] d, input logic sof, input logic eof);
    logic [3:0] oh;
    oh = 4'b0001 << ch;
    exp_q.push_back({oh, d, sof, eof});
  endtask

  task automatic expect_pkt(input int ch, input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) exp_word(ch, base + 32'(k), (k == 0), (k == n - 1));
  endtask

  task automatic drive_heads();
    for (int i = 0; i < NCH; i++) begin
      if (src_q[i].size() > 0) begin
        Ch_Valid[i]         = 1'b1;
        Ch_Data[32*i +: 32] = src_q[i][0].d;
        Ch_Last[i]          = src_q[i][0].l;
      end else begin
        Ch_Valid[i]         = 1'b0;
        Ch_Data[32*i +: 32] = '0;
        Ch_Last[i]          = 1'b0;
      end
    end
  endtask

  function automatic bit all_src_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NCH; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  // Sources: handshake decided by the values stable before the rising edge.
  initial begin : driver
    logic [NCH-1:0] fire;
    forever begin
      @(negedge clk);
      fire = Ch_Valid & Ch_Ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NCH; i++) if (fire[i]) void'(src_q[i].pop_front());
      drive_heads();
    end
  end

  // Monitor: every push is checked against the next expected entry.
  initial begin : monitor
    logic [37:0] e;
    forever begin
      @(negedge clk);
      if (FB_PKfbPush != '0) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_push: got push=%b data=0x%0h expected no push",
                   FB_PKfbPush, FB_PKfbData);
        end else begin
          e = exp_q.pop_front();
          check("push_word", {FB_PKfbPush, FB_PKfbData, FB_PKfbSOF, FB_PKfbEOF}, e);
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      done = all_src_empty() && !Busy && (exp_q.size() == 0);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (!done || exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: got %0d pending expected pushes, busy=%b, expected 0 and idle",
               name, exp_q.size(), Busy);
    end
  endtask

  task automatic wait_push(input logic [3:0] push, input logic [31:0] data, input string name);
    int n;
    n = 0;
    while (!(FB_PKfbPush == push && FB_PKfbData == data) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, {FB_PKfbPush, FB_PKfbData}, {push, data});
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    rst_n           = 1'b0;
    Ch_Valid        = '0;
    Ch_Data         = '0;
    Ch_Last         = '0;
    FB_PKfbOverflow = 1'b0;
    Ovf_Clr         = '0;
    TimeStamp       = 24'h123456;

    // Contention: ch1 (two packets) and ch3 valid from reset.
    send(1, 32'h11, 2);
    send(1, 32'h13, 2);
    send(3, 32'h31, 2);
    expect_pkt(1, 32'h11, 2);
    expect_pkt(3, 32'h31, 2);
    expect_pkt(1, 32'h13, 2);

    repeat (3) @(negedge clk);
    check("reset_outputs", {FB_PKfbData, FB_PKfbPush, FB_PKfbSOF, FB_PKfbEOF, Ovf_Sticky, Busy}, '0);
    check("reset_ready", Ch_Ready, '0);
    rst_n = 1'b1;
    wait_idle("contention");

    // Single 3-word packet on ch0, pushes in consecutive cycles.
    send(0, 32'hA0, 3);
    expect_pkt(0, 32'hA0, 3);
    n = 0;
    while (FB_PKfbPush == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("single_push_c1", FB_PKfbPush, 4'b0001);
    @(negedge clk);
    check("single_push_c2", FB_PKfbPush, 4'b0001);
    @(negedge clk);
    check("single_push_c3", FB_PKfbPush, 4'b0001);
    @(negedge clk);
    check("single_push_end", FB_PKfbPush, 4'b0000);
    wait_idle("single");
    check("single_busy", Busy, 1'b0);

    // Max length 4: 6-word source packet splits 4 + 2.
    send(0, 32'hB0, 6);
    expect_pkt(0, 32'hB0, 4);
    expect_pkt(0, 32'hB4, 2);
    wait_idle("maxlen");

    // Overflow while word 2 is on the push port; words 3..8 drained.
    send(2, 32'hC0, 8);
    exp_word(2, 32'hC0, 1'b1, 1'b0);
    exp_word(2, 32'hC1, 1'b0, 1'b0);
    wait_push(4'b0100, 32'hC1, "ovf_word2_seen");
    FB_PKfbOverflow = 1'b1;
    @(negedge clk);
    FB_PKfbOverflow = 1'b0;
    wait_idle("overflow");
    check("ovf_sticky", Ovf_Sticky, 4'b0100);

    // Set and clear together on ch2: set wins; clear alone then clears.
    send(2, 32'hD0, 4);
    n = 0;
    while (!Ch_Ready[2] && n < 50) begin
      @(negedge clk);
      n++;
    end
    FB_PKfbOverflow = 1'b1;
    Ovf_Clr         = 4'b0100;
    @(negedge clk);
    FB_PKfbOverflow = 1'b0;
    check("sticky_set_wins", Ovf_Sticky, 4'b0100);
    @(negedge clk);
    Ovf_Clr = '0;
    check("sticky_clear", Ovf_Sticky, 4'b0000);
    wait_idle("sticky");

    // Overflow seen while idle is ignored.
    FB_PKfbOverflow = 1'b1;
    @(negedge clk);
    FB_PKfbOverflow = 1'b0;
    @(negedge clk);
    check("idle_ovf_ignored", Ovf_Sticky, 4'b0000);
    check("idle_busy", Busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
